mvm_job_arbiter: RTL and testbench
==================================

MVM_JOB_ARBITER -- requirements
Module: mvm_job_arbiter

Interface
REQ-001 Parameter K, default 32: matrix dimension of the shared MVM engine.
REQ-002 Parameter logK, default 6: address width basis; counters SHALL be 2*logK+1 bits wide.
REQ-003 Parameter b, default 8: input word width; engine result width is 2*b.
REQ-004 Parameter TIMEOUT, default 4096: maximum cycles from mvm_start to mvm_done.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req  in  2  per-client job request, bit i = client i.
REQ-008 gnt  out  2  one-hot grant; held for the whole job.
REQ-009 in_data  in  b  streamed operand word from the granted client.
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  arbiter consumes in_data this cycle.
REQ-012 out_data  out  2*b  result word y[i].
REQ-013 out_valid  out  1  out_data valid; no backpressure.
REQ-014 out_id  out  1  client index owning out_data.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err  out  1  one-cycle abort pulse.
REQ-017 mvm_reset, mvm_load_matrix, mvm_load_vector, mvm_start  out  1 each  engine controls.
REQ-018 mvm_data_in  out  b  engine input word.
REQ-019 mvm_done  in  1, mvm_data_out  in  2*b  engine status and result.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD_A, XFER_A, LOAD_X, XFER_X, START, WAIT, DRAIN.
REQ-021 In IDLE with any req bit set, the arbiter SHALL grant one client round-robin; gnt asserts the next cycle and the FSM enters LOAD_A.
REQ-022 Round-robin: on simultaneous requests, the client not served last wins; after reset, client 0 wins.
REQ-023 LOAD_A SHALL last one cycle with mvm_load_matrix=1 and in_ready=0; then XFER_A.
REQ-024 XFER_A SHALL last exactly K*K cycles with in_ready=1 and mvm_data_in=in_data; then LOAD_X.
REQ-025 LOAD_X SHALL last one cycle with mvm_load_vector=1; XFER_X SHALL last exactly K cycles with in_ready=1; then START.
REQ-026 START SHALL last one cycle with mvm_start=1; then WAIT.
REQ-027 WAIT SHALL hold until mvm_done=1; DRAIN SHALL start the next cycle.
REQ-028 DRAIN SHALL last K cycles; in each cycle, out_valid=1, out_data=mvm_data_out and out_id=granted client; word i SHALL appear in DRAIN cycle i.
REQ-029 After DRAIN, the FSM SHALL enter IDLE, drop gnt and record the served client; a new grant is possible no earlier than the cycle after IDLE is entered.
REQ-030 mvm_data_in SHALL be 0 whenever in_ready=0; the engine control outputs SHALL be 0 outside their defined cycles.
REQ-031 Changes on req during a job SHALL be ignored; req of the granted client is not required to stay high.
REQ-032 in_valid=0 in any XFER cycle is an abort: err=1 and mvm_reset=1 for one cycle, gnt=0 the following cycle, return to IDLE with no mvm_start, and last-served updated to the aborted client.
REQ-033 The WAIT counter reaching TIMEOUT without mvm_done is an abort handled as in REQ-032.
REQ-034 mvm_done outside WAIT SHALL be ignored.

Reset
REQ-035 Reset SHALL force IDLE and set gnt, in_ready, out_valid, out_id, busy, err, mvm_load_matrix, mvm_load_vector, mvm_start, mvm_data_in and out_data to 0.
REQ-036 Reset SHALL clear the counters and the last-served pointer, so client 0 has priority.
REQ-037 mvm_reset SHALL equal reset OR the abort pulse.
REQ-038 Reset in any state, including mid-XFER or mid-DRAIN, SHALL take effect the next cycle with no further out_valid.

Verification (K=4, logK=3, real mvm engine)
REQ-039 req=01, A=identity, x={1,2,3,4} -> gnt=01; 16+4 in_ready cycles; out_data 1,2,3,4 with out_id=0; gnt=00 after the 4th word.
REQ-040 Starting after reset: req=11 held for two jobs -> client 0 served first, then client 1; a third job with req=11 -> client 0.
REQ-041 in_valid=0 at XFER_A word 5 -> err=1 and mvm_reset=1 for one cycle; no mvm_start; gnt=00 the next cycle.
REQ-042 Engine model withholds mvm_done -> err exactly TIMEOUT cycles after mvm_start; busy=0 afterwards.
REQ-043 Reset asserted during WAIT -> all outputs 0 the next cycle; a following job with A=all 2, x={1,1,1,1} -> outputs 8,8,8,8.
REQ-044 Signed case: A row 0={-1,0,0,0}, other rows 0, x={127,0,0,0} -> y[0]=-127 (0xFF81), y[1..3]=0.

Source files
------------

// File: rtl/mvm_job_arbiter.sv
// mvm_job_arbiter: round-robin arbiter that serializes two clients' jobs onto one shared MVM engine
module mvm_job_arbiter #(
   parameter int K       = 32,
   parameter int logK    = 6,
   parameter int b       = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     req,
   output logic [1:0]     gnt,
   input  logic [b-1:0]   in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [2*b-1:0] out_data,
   output logic           out_valid,
   output logic           out_id,
   output logic           busy,
   output logic           err,
   output logic           mvm_reset,
   output logic           mvm_load_matrix,
   output logic           mvm_load_vector,
   output logic           mvm_start,
   output logic [b-1:0]   mvm_data_in,
   input  logic           mvm_done,
   input  logic [2*b-1:0] mvm_data_out
);
   localparam int CW = 2*logK+1;
   localparam int WW = $clog2(TIMEOUT)+1;
   localparam logic [CW-1:0] LAST_A = CW'(K*K-1);
   localparam logic [CW-1:0] LAST_X = CW'(K-1);
   localparam logic [WW-1:0] LAST_W = WW'(TIMEOUT-1);

   typedef enum logic [2:0] {IDLE, LOAD_A, XFER_A, LOAD_X, XFER_X, START, WAIT, DRAIN} state_t;

   state_t        r_state, w_state;
   logic [CW-1:0] r_cnt;
   logic [WW-1:0] r_wcnt;
   logic          r_id, r_prio;
   logic          w_xfer, w_abort, w_pick;

   // next-state decode, abort detection and Moore-style outputs from the current state
   always_comb begin
      w_xfer          = (r_state == XFER_A) || (r_state == XFER_X);
      w_abort         = (w_xfer && !in_valid) || (r_state == WAIT && !mvm_done && r_wcnt == LAST_W);
      w_pick          = (req == 2'b11) ? r_prio : req[1];
      w_state         = r_state;
      case (r_state)
         IDLE:    w_state = |req ? LOAD_A : IDLE;
         LOAD_A:  w_state = XFER_A;
         XFER_A:  w_state = w_abort ? IDLE : (r_cnt == LAST_A) ? LOAD_X : XFER_A;
         LOAD_X:  w_state = XFER_X;
         XFER_X:  w_state = w_abort ? IDLE : (r_cnt == LAST_X) ? START : XFER_X;
         START:   w_state = WAIT;
         WAIT:    w_state = mvm_done ? DRAIN : w_abort ? IDLE : WAIT;
         DRAIN:   w_state = (r_cnt == LAST_X) ? IDLE : DRAIN;
         default: w_state = IDLE;
      endcase
      busy            = r_state != IDLE;
      gnt             = busy ? (r_id ? 2'b10 : 2'b01) : 2'b00;
      in_ready        = w_xfer;
      mvm_data_in     = w_xfer ? in_data : '0;
      out_valid       = r_state == DRAIN;
      out_data        = out_valid ? mvm_data_out : '0;
      out_id          = out_valid && r_id;
      err             = w_abort;
      mvm_reset       = reset || w_abort;
      mvm_load_matrix = r_state == LOAD_A;
      mvm_load_vector = r_state == LOAD_X;
      mvm_start       = r_state == START;
   end

   // state, phase counters, granted client and round-robin priority pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wcnt  <= '0;
         r_id    <= 1'b0;
         r_prio  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= (w_state == r_state) ? r_cnt + 1'b1 : '0;
         r_wcnt  <= (r_state == WAIT) ? r_wcnt + 1'b1 : '0;
         if (r_state == IDLE && |req) r_id <= w_pick;
         if (w_abort || (r_state == DRAIN && w_state == IDLE)) r_prio <= ~r_id;
      end
   end
endmodule

// File: tb/tb_mvm_job_arbiter.sv
// tb_mvm_job_arbiter: scoreboard bench with a behavioural MVM engine for the job arbiter
module tb_mvm_job_arbiter;
   localparam int K = 4, LOGK = 3, B = 8, TO = 64;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready, out_valid, out_id, busy, err;
   logic          mvm_reset, mvm_load_matrix, mvm_load_vector, mvm_start, mvm_done;
   logic [1:0]    req, gnt;
   logic [7:0]    in_data, mvm_data_in;
   logic [15:0]   out_data, mvm_data_out;
   logic          e_done, e_hold, spur;

   logic signed [7:0]  ea [16];
   logic signed [7:0]  ex [4];
   logic signed [15:0] ey [4];
   int                 e_st, e_i, e_lat;

   int          n_checks, n_errs, n_rdy, n_start, n_err, cyc, start_cyc, err_cyc;
   bit          prev_err, prev_ov;
   logic [16:0] sbq[$];
   logic [7:0]  s_buf [20];
   logic [15:0] y_exp [4];

   always #5 clk = ~clk;

   mvm_job_arbiter #(.K(K), .logK(LOGK), .b(B), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .gnt(gnt), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_id(out_id),
      .busy(busy), .err(err), .mvm_reset(mvm_reset), .mvm_load_matrix(mvm_load_matrix),
      .mvm_load_vector(mvm_load_vector), .mvm_start(mvm_start), .mvm_data_in(mvm_data_in),
      .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
   );

   function automatic logic signed [15:0] dot(input int r);
      int s = 0;
      for (int j = 0; j < 4; j++) s += int'(ea[r*4+j]) * int'(ex[j]);
      return 16'(s);
   endfunction

   // engine: load A and x after their load pulses, compute on start, done after a short latency, then stream y
   always @(posedge clk) begin
      if (mvm_reset) e_st <= 0;
      else if (mvm_load_matrix) begin e_st <= 1; e_i <= 0; end
      else if (mvm_load_vector) begin e_st <= 2; e_i <= 0; end
      else if (mvm_start) begin
         e_st <= 3; e_lat <= 2;
         for (int r = 0; r < 4; r++) ey[r] <= dot(r);
      end
      else if (e_st == 1 && e_i < 16) begin ea[e_i] <= mvm_data_in; e_i <= e_i + 1; end
      else if (e_st == 2 && e_i < 4) begin ex[e_i] <= mvm_data_in; e_i <= e_i + 1; end
      else if (e_st == 3 && !e_hold) begin
         if (e_lat == 0) begin e_st <= 4; e_i <= 0; end
         else e_lat <= e_lat - 1;
      end
      else if (e_st == 4) e_i <= e_i + 1;
   end

   assign e_done       = (e_st == 3) && (e_lat == 0) && !e_hold;
   assign mvm_done     = e_done || spur;
   assign mvm_data_out = (e_st == 4 && e_i < 4) ? ey[e_i[1:0]] : 16'hDEAD;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon();
      logic [16:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            if (in_ready) n_rdy++;
            else chk("data_in_idle_zero", 64'(mvm_data_in), 0);
            if (mvm_start) begin n_start++; start_cyc = cyc; end
            if (err) begin n_err++; err_cyc = cyc; chk("mvm_reset_on_err", 64'(mvm_reset), 1); end
            if (prev_err) chk("gnt_after_err", 64'(gnt), 0);
            if (prev_ov && !out_valid) chk("gnt_after_drain", 64'(gnt), 0);
            if (out_valid) begin
               if (sbq.size() == 0) begin
                  n_checks++; n_errs++;
                  $display("FAIL unexpected_out: got id %0d data %0h expected none", out_id, out_data);
               end else begin
                  e = sbq.pop_front();
                  chk("out_data", 64'(out_data), 64'(e[15:0]));
                  chk("out_id", 64'(out_id), 64'(e[16]));
               end
            end
         end
         prev_err = err;
         prev_ov  = out_valid;
      end
   endtask

   task automatic set_ident(input int base);
      for (int i = 0; i < 16; i++) s_buf[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
      for (int j = 0; j < 4; j++) begin s_buf[16+j] = 8'(base + j); y_exp[j] = 16'(base + j); end
   endtask

   // mode: 0 normal, 1 engine withholds done, 2 reset during WAIT, 3 spurious done during XFER
   task automatic run_job(input logic [1:0] rq, input bit drop, input int exp_id, input int abort_at,
                          input int mode, input int exp_rdy, input int exp_start, input int exp_err);
      int r0, s0, e0, k, t;
      bit seen, did, fin;
      r0 = n_rdy; s0 = n_start; e0 = n_err; k = 0; t = 0; seen = 0; did = 0; fin = 0;
      if (abort_at < 0 && mode != 1 && mode != 2)
         for (int i = 0; i < 4; i++) sbq.push_back({exp_id[0], y_exp[i]});
      e_hold = (mode == 1 || mode == 2);
      req = rq;
      while (t < 400 && !fin) begin
         @(posedge clk); #1; t++;
         if (did) begin
            chk("rst_in_wait_outs", 64'({gnt, busy, in_ready, out_valid, out_id, err, mvm_load_matrix,
                                        mvm_load_vector, mvm_start, mvm_data_in, out_data}), 0);
            reset = 1'b0; fin = 1;
         end else if (mode == 2 && n_start != s0) begin
            reset = 1'b1; did = 1;
         end else if (busy && !seen) begin
            seen = 1;
            chk("gnt", 64'(gnt), exp_id ? 2 : 1);
            chk("load_a", 64'({mvm_load_matrix, in_ready, mvm_load_vector, mvm_start}), 4'b1000);
            if (drop) req = 2'b00;
         end else if (!busy && seen) fin = 1;
         spur = (mode == 3) && in_ready;
         if (in_ready && k < 20) begin in_data = s_buf[k]; in_valid = (k != abort_at); k++; end
         else begin in_data = 8'hA5; in_valid = 1'b0; end
      end
      if (!fin) begin
         n_checks++; n_errs++;
         $display("FAIL job_timeout: got no job completion expected completion within 400 cycles");
      end
      chk("rdy_cnt", 64'(n_rdy - r0), 64'(exp_rdy));
      chk("start_cnt", 64'(n_start - s0), 64'(exp_start));
      chk("err_cnt", 64'(n_err - e0), 64'(exp_err));
      spur = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = 2'b00; in_data = '0; in_valid = 1'b0; e_hold = 1'b0; spur = 1'b0;
      fork mon(); join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 64'({gnt, busy, in_ready, out_valid, out_id, err, mvm_load_matrix,
                            mvm_load_vector, mvm_start, mvm_data_in, out_data}), 0);
      chk("reset_mvm_reset", 64'(mvm_reset), 1);
      @(posedge clk); #1 reset = 1'b0;
      set_ident(1);
      run_job(2'b01, 1, 0, -1, 0, 20, 1, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      set_ident(5);
      run_job(2'b11, 0, 0, -1, 0, 20, 1, 0);
      set_ident(9);
      run_job(2'b11, 0, 1, -1, 0, 20, 1, 0);
      set_ident(13);
      run_job(2'b11, 1, 0, -1, 0, 20, 1, 0);
      run_job(2'b01, 1, 0, 5, 0, 6, 0, 1);
      set_ident(1);
      run_job(2'b01, 1, 0, -1, 1, 20, 1, 1);
      chk("timeout_latency", 64'(err_cyc - start_cyc), TO);
      chk("busy_after_timeout", 64'(busy), 0);
      run_job(2'b01, 1, 0, -1, 2, 20, 1, 0);
      for (int i = 0; i < 16; i++) s_buf[i] = 8'd2;
      for (int j = 0; j < 4; j++) begin s_buf[16+j] = 8'd1; y_exp[j] = 16'd8; end
      run_job(2'b10, 1, 1, -1, 0, 20, 1, 0);
      for (int i = 0; i < 20; i++) s_buf[i] = 8'd0;
      s_buf[0] = 8'hFF; s_buf[16] = 8'd127;
      y_exp[0] = 16'hFF81; y_exp[1] = 16'd0; y_exp[2] = 16'd0; y_exp[3] = 16'd0;
      run_job(2'b01, 1, 0, -1, 3, 20, 1, 0);
      repeat (2) @(posedge clk);
      chk("sb_drained", 64'(sbq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
